color_sensor_sampler: RTL and testbench

- Front-end producer for the colour-normalisation datapath. Drives the TCS3200-style filter selects (s2/s3) and counts sensor_out pulses over a fixed gate window for each filter in turn: clear, red, green, blue.
- Presents the four raw counts as one atomic set with a valid/ready handshake. The Division stage consumes these as its Color/Clear operands.

---
 rtl/color_sensor_sampler.sv | 178 +++++++++++++++++
 tb/tb_color_sensor_sampler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_sensor_sampler.sv
// color_sensor_sampler
//   Drives the TCS3200-style filter selects and counts sensor_out rising edges
//   over a fixed gate window for each filter in turn (clear, red, green, blue).
//   The four counts are presented together as one set with a valid/ready
//   handshake.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : single-cycle request for one four-filter sweep
//   sensor_out          : asynchronous pulse train from the sensor
//   s2, s3              : filter select bits
//   busy                : sweep in progress (SETTLE, COUNT, PRESENT)
//   clear_cnt .. blue_cnt : result counts, WIDTH bits each
//   valid, ready        : result handshake

module color_sensor_sampler #(
  parameter int WIDTH         = 15,
  parameter int SETTLE_CYCLES = 1000,
  parameter int WINDOW_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sensor_out,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic [WIDTH-1:0] clear_cnt,
  output logic [WIDTH-1:0] red_cnt,
  output logic [WIDTH-1:0] green_cnt,
  output logic [WIDTH-1:0] blue_cnt,
  output logic             valid,
  input  logic             ready
);

  localparam int MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, PRESENT} state_t;
  // Order of this enum is the sweep order.
  typedef enum logic [1:0] {F_CLEAR, F_RED, F_GREEN, F_BLUE} filter_t;

  // Filter select encoding as {s2, s3}.
  function automatic logic [1:0] filter_sel(filter_t f);
    case (f)
      F_CLEAR: filter_sel = 2'b10;
      F_RED:   filter_sel = 2'b00;
      F_GREEN: filter_sel = 2'b11;
      default: filter_sel = 2'b01;
    endcase
  endfunction

  state_t           state_q;
  filter_t          filter_q;
  filter_t          filter_nxt;
  logic [TW-1:0]    timer_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] shadow_q [4];
  logic [WIDTH-1:0] clear_q, red_q, green_q, blue_q;
  logic             s2_q, s3_q, busy_q, valid_q;

  // Input path: two synchroniser flops plus a history flop for edge detection.
  logic sync1_q, sync2_q, prev_q;
  logic rise_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its neighbour; blocking here would collapse the chain.
      sync1_q <= sensor_out;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_det   = sync2_q & ~prev_q;
  assign filter_nxt = filter_t'(filter_q + 2'd1);

  // Saturating edge counter: holds at all-ones instead of wrapping.
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned,
    // which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (rise_det && (cnt_q != CNT_MAX)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      filter_q <= F_CLEAR;
      timer_q  <= '0;
      cnt_q    <= '0;
      // NOTE: the shadow words are reset along with everything else; there
      // are only four, and it keeps an aborted sweep's data from lingering.
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      clear_q  <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= SETTLE;
            filter_q     <= F_CLEAR;
            {s2_q, s3_q} <= filter_sel(F_CLEAR);
            timer_q      <= '0;
            busy_q       <= 1'b1;
          end
        end

        // Edges are still tracked by the input path but not counted here.
        SETTLE: begin
          if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
            state_q <= COUNT;
            timer_q <= '0;
            cnt_q   <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        COUNT: begin
          cnt_q <= cnt_d;
          if (timer_q == TW'(WINDOW_CYCLES - 1)) begin
            // Include an edge seen on the final window cycle.
            shadow_q[filter_q] <= cnt_d;
            timer_q            <= '0;
            if (filter_q == F_BLUE) begin
              state_q <= PRESENT;
            end else begin
              filter_q     <= filter_nxt;
              {s2_q, s3_q} <= filter_sel(filter_nxt);
              state_q      <= SETTLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        // First PRESENT cycle publishes the set; it then holds until accepted.
        PRESENT: begin
          if (!valid_q) begin
            clear_q <= shadow_q[F_CLEAR];
            red_q   <= shadow_q[F_RED];
            green_q <= shadow_q[F_GREEN];
            blue_q  <= shadow_q[F_BLUE];
            valid_q <= 1'b1;
          end else if (ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign s2        = s2_q;
  assign s3        = s3_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign clear_cnt = clear_q;
  assign red_cnt   = red_q;
  assign green_cnt = green_q;
  assign blue_cnt  = blue_q;

endmodule

// File: tb/tb_color_sensor_sampler.sv
// Bench for color_sensor_sampler: a cycle-indexed behavioural model (sweep
// timeline by arithmetic on the cycles since start, counts from a log of the
// sensor samples) checked every cycle, plus hand-computed literal checks and a
// second narrow instance for count saturation.
module tb_color_sensor_sampler;

  localparam int S     = 4;
  localparam int W     = 20;
  localparam int WD    = 15;
  localparam int SW    = S + W;
  localparam int SWEEP = 4 * SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, sensor_out = 1'b0, ready = 1'b0;
  logic s2, s3, busy, valid;
  logic [WD-1:0] clear_cnt, red_cnt, green_cnt, blue_cnt;

  logic start_s = 1'b0, sensor_s = 1'b0, ready_s = 1'b1;
  logic s2_s, s3_s, busy_s, valid_s;
  logic [3:0] clear_s, red_s, green_s, blue_s;

  always #5 clk = ~clk;

  color_sensor_sampler #(.WIDTH(WD), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sensor_out(sensor_out),
    .s2(s2), .s3(s3), .busy(busy),
    .clear_cnt(clear_cnt), .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
    .valid(valid), .ready(ready));

  color_sensor_sampler #(.WIDTH(4), .SETTLE_CYCLES(4), .WINDOW_CYCLES(40)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .sensor_out(sensor_s),
    .s2(s2_s), .s3(s3_s), .busy(busy_s),
    .clear_cnt(clear_s), .red_cnt(red_s), .green_cnt(green_s), .blue_cnt(blue_s),
    .valid(valid_s), .ready(ready_s));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sensor stimulus: period chosen by current filter ----------
  int per [4];
  bit noise = 1'b0;
  int ph = 0;
  int last_f = -1;

  function automatic int filt_of(logic a, logic b);
    case ({a, b})
      2'b10:   return 0;  // clear
      2'b00:   return 1;  // red
      2'b11:   return 2;  // green
      default: return 3;  // blue
    endcase
  endfunction

  always @(negedge clk) begin : gen
    int f;
    f = filt_of(s2, s3);
    if (f != last_f) ph = 0;
    last_f = f;
    if (noise) begin
      sensor_out = 1'($urandom % 2);
    end else begin
      sensor_out = (ph < per[f] / 2);
      ph = (ph + 1) % per[f];
    end
  end

  always @(negedge clk) sensor_s = ~sensor_s;

  // ---------------- behavioural model ----------------
  localparam bit [1:0] SEL [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
  bit smp [0:65535];
  int cyc = 0;
  bit m_active, m_valid, m_busy, m_s2, m_s3;
  int m_e0;
  int m_cnt [4];

  // Rising edges visible to the counter: the edge seen at posedge k reflects
  // sensor samples taken two and three posedges earlier.
  function automatic int exp_count(int e0, int f);
    int base, c;
    base = e0 + f * SW;
    c = 0;
    for (int k = base + S + 1; k <= base + SW; k++)
      if (smp[k-2] && !smp[k-3]) c++;
    if (c > (1 << WD) - 1) c = (1 << WD) - 1;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int d;
    if (!rst_n) begin
      m_active = 0; m_valid = 0; m_busy = 0; m_s2 = 0; m_s3 = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      cyc++;
      smp[cyc] = sensor_out;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_busy = 1; m_e0 = cyc;
          {m_s2, m_s3} = SEL[0];
        end
      end else if (m_valid && ready) begin
        m_active = 0; m_valid = 0; m_busy = 0;
      end else begin
        d = cyc - m_e0;
        if (d < SWEEP) {m_s2, m_s3} = SEL[d / SW];
        else if (d == SWEEP + 1) begin
          for (int i = 0; i < 4; i++) m_cnt[i] = exp_count(m_e0, i);
          m_valid = 1;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      check("s2", s2, m_s2);
      check("s3", s3, m_s3);
      check("busy", busy, m_busy);
      check("valid", valid, m_valid);
      check("clear_cnt", clear_cnt, m_cnt[0]);
      check("red_cnt", red_cnt, m_cnt[1]);
      check("green_cnt", green_cnt, m_cnt[2]);
      check("blue_cnt", blue_cnt, m_cnt[3]);
    end
  end

  int vrise = 0;
  bit valid_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (valid && !valid_prev) vrise++;
    valid_prev = valid;
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (valid) break;
      if (lat >= 400) begin
        check({nm, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic check_counts(input string nm, input int c, input int r, input int g, input int b);
    check({nm, "_clear"}, clear_cnt, c);
    check({nm, "_red"}, red_cnt, r);
    check({nm, "_green"}, green_cnt, g);
    check({nm, "_blue"}, blue_cnt, b);
  endtask

  task automatic accept();
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, v0, sweeps;
    per = '{2, 4, 5, 10};
    #1;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_s2s3", {s2, s3}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Basic sweep with fixed periods and latency.
    pulse_start();
    wait_valid("basic", lat);
    check("basic_latency", lat, 97);
    check_counts("basic", 10, 5, 4, 2);

    // Backpressure: 30 cycles of ready=0, results must hold.
    repeat (30) @(posedge clk);
    #1;
    check("bp_valid_held", valid, 1);
    check_counts("bp_hold", 10, 5, 4, 2);
    accept();
    check("bp_valid_drop", valid, 0);
    check("bp_busy_drop", busy, 0);
    check_counts("idle_hold", 10, 5, 4, 2);

    // start while busy (during red COUNT) must be ignored.
    v0 = vrise;
    pulse_start();
    repeat (35) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_valid("busy_start", lat);
    check_counts("busy_start", 10, 5, 4, 2);
    accept();
    repeat (150) @(negedge clk);
    check("busy_start_one_valid", vrise - v0, 1);
    check("busy_start_idle", busy, 0);

    // Reset during green COUNT; async reset clears outputs immediately.
    pulse_start();
    repeat (60) @(negedge clk);
    check("pre_rst_s2s3", {s2, s3}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("arst_s2s3", {s2, s3}, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check_counts("arst", 0, 0, 0, 0);
    per = '{4, 2, 10, 5};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    v0 = vrise;
    pulse_start();
    wait_valid("post_rst", lat);
    check("post_rst_latency", lat, 97);
    check_counts("post_rst", 5, 10, 2, 4);
    check("post_rst_one_valid", vrise - v0, 1);
    accept();

    // Saturation on the 4-bit instance: 20 edges per window clamp to 15.
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    lat = 0;
    while (!valid_s && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("sat_valid", valid_s, 1);
    check("sat_clear", clear_s, 15);
    check("sat_red", red_s, 15);
    check("sat_green", green_s, 15);
    check("sat_blue", blue_s, 15);

    // Randomised traffic: random periods or noise, random start/ready.
    v0 = vrise;
    repeat (4000) begin
      @(negedge clk);
      if (!busy && ($urandom % 5 == 0)) begin
        for (int i = 0; i < 4; i++) per[i] = int'($urandom_range(13, 2));
        noise = ($urandom % 4 == 0);
      end
      start = ($urandom % 40 == 0);
      ready = ($urandom % 3 == 0);
    end
    start = 1'b0;
    ready = 1'b0;
    sweeps = vrise - v0;
    check("random_sweeps_seen", int'(sweeps >= 5), 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
